// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-cycle adder that time-multiplexes one SLICE-bit
// ripple-carry slice across a WIDTH-bit add, LSB slice first, with the
// inter-slice carry held in a register between cycles.
// WIDTH must be an integer multiple of SLICE, and at least SLICE.
// Optional feature macro: RCA_SEQ_OVF_EN adds the signed-overflow output ovf.
module rca_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf_q;
`endif

  logic [SLICE-1:0] x_slice;
  logic [SLICE-1:0] y_slice;
  logic [SLICE:0]   slice_sum;
  logic [SLICE-1:0] slice_d;
  logic             carry_d;

  // Slice datapath: add the current operand slices plus the stored carry at full SLICE+1 width.
  always_comb begin
    // NOTE: every always_comb output gets an unconditional value first so no
    // path leaves it unassigned, which is what keeps latches from being inferred.
    x_slice   = '0;
    y_slice   = '0;
    x_slice   = x_q[idx_q*SLICE +: SLICE];
    y_slice   = y_q[idx_q*SLICE +: SLICE];
    slice_sum = {1'b0, x_slice} + {1'b0, y_slice} + {{SLICE{1'b0}}, carry_q};
    slice_d   = slice_sum[SLICE-1:0];
    carry_d   = slice_sum[SLICE];
  end

  // Sequencer FSM: accept in IDLE, one slice per RUN edge, one-cycle done pulse in DONE.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments only, so every register in
    // this block samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      // NOTE: the operand registers are reset along with everything else; they
      // are few enough that a known post-reset value costs nothing worth saving.
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            carry_q <= c_in;
            idx_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end

        RUN: begin
          s_q[idx_q*SLICE +: SLICE] <= slice_d;
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            // Final slice: publish the carry and wrap the index back to 0.
            c_out_q <= carry_d;
            idx_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef RCA_SEQ_OVF_EN
            // Like-signed operands producing a result of the other sign.
            ovf_q   <= (x_q[WIDTH-1] == y_q[WIDTH-1]) &&
                       (slice_d[SLICE-1] != x_q[WIDTH-1]);
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign s     = s_q;
  assign c_out = c_out_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
